// File: rtl/booth4_multiplier.sv
// Radix-4 Booth sequential signed multiplier, WIDTH/2 iterations plus one DONE cycle; beginSignal is ignored while busy.
// Optional BOOTH4_DIGIT_TRACE_EN exposes the recoded digit (sign-magnitude) each ITER cycle.
module booth4_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 beginSignal,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 endSignal,
  output logic                 busy,
  output logic [1:0]           state
`ifdef BOOTH4_DIGIT_TRACE_EN
  ,
  output logic [2:0]           digit,
  output logic                 digit_valid
`endif
);

  localparam int AW = WIDTH + 2;
  localparam int CW = (WIDTH > 4) ? $clog2(WIDTH / 2) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       a_q, a_d;
  logic [AW-1:0]       m_q, m_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic                q1_q, q1_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  prod_q, prod_d;

  logic [2:0]          trip;
  logic [AW-1:0]       m2;
  logic [AW-1:0]       addend;
  logic [AW-1:0]       sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    trip   = {q_q[1:0], q1_q};
    m2     = {m_q[AW-2:0], 1'b0};
    addend = '0;
    case (trip)
      3'b001, 3'b010: addend = m_q;
      3'b011:         addend = m2;
      3'b100:         addend = -m2;
      3'b101, 3'b110: addend = -m_q;
      default:        addend = '0;
    endcase
    sum = a_q + addend;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    endSignal = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (beginSignal) begin
          m_d     = {{2{multiplicand[WIDTH-1]}}, multiplicand};
          q_d     = multiplier;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = CW'(WIDTH / 2 - 1);
          state_d = ITER;
        end
      end
      ITER: begin
        busy = 1'b1;
        // Arithmetic shift of {S, Q, q_1} right by two.
        a_d  = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_d  = {sum[1:0], q_q[WIDTH-1:2]};
        q1_d = q_q[1];
        if (cnt_q == '0) begin
          // Product is latched on entry to DONE so it is already valid while endSignal is high.
          prod_d  = {a_d[WIDTH-1:0], q_d};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        endSignal = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = prod_q;
  assign state   = state_q;

`ifdef BOOTH4_DIGIT_TRACE_EN
  always_comb begin
    digit_valid = (state_q == ITER);
    digit       = 3'b000;
    if (digit_valid) begin
      case (trip)
        3'b001, 3'b010: digit = 3'b001;
        3'b011:         digit = 3'b010;
        3'b100:         digit = 3'b110;
        3'b101, 3'b110: digit = 3'b101;
        default:        digit = 3'b000;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_booth4_multiplier.sv
// Directed-vector bench for booth4_multiplier at WIDTH=8, plus handshake corner sequences.
module tb_booth4_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           beginSignal = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic [2*W-1:0] product;
  logic           endSignal;
  logic           busy;
  logic [1:0]     state;
`ifdef BOOTH4_DIGIT_TRACE_EN
  logic [2:0]     digit;
  logic           digit_valid;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth4_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .beginSignal  (beginSignal),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .endSignal    (endSignal),
    .busy         (busy),
    .state        (state)
`ifdef BOOTH4_DIGIT_TRACE_EN
    ,
    .digit        (digit),
    .digit_valid  (digit_valid)
`endif
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One operation from IDLE; optionally re-pulses beginSignal with new operands at cycle 'poke'.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                       input string name, input int poke);
    int ends;
    int endcyc;
    int busyc;
    ends = 0; endcyc = 0; busyc = 0;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    beginSignal  = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (busy) busyc++;
      if (endSignal) begin
        ends++;
        endcyc = k;
        check({name, ".product"}, {16'h0, product}, {16'h0, exp});
      end
      if (k == 1) beginSignal = 1'b0;
      if (k == poke) begin
        beginSignal  = 1'b1;
        multiplicand = 8'd100;
        multiplier   = 8'hFD;
      end
      if (k == poke + 1) beginSignal = 1'b0;
    end
    check({name, ".ends"}, ends, 1);
    check({name, ".endcyc"}, endcyc, 5);
    check({name, ".busycyc"}, busyc, 5);
    check({name, ".held"}, {16'h0, product}, {16'h0, exp});
  endtask

  initial begin
    vec_t vecs[10];
    int   ends;
    int   endcyc[3];
    logic [15:0] prods[3];
    logic signed [7:0]  ra, rb;
    logic signed [15:0] rp;

    vecs[0] = '{8'd7,   8'd3,   16'h0015};
    vecs[1] = '{8'h80,  8'h80,  16'h4000};
    vecs[2] = '{8'h80,  8'h7F,  16'hC080};
    vecs[3] = '{8'hFF,  8'hFF,  16'h0001};
    vecs[4] = '{8'h00,  8'hC7,  16'h0000};
    vecs[5] = '{8'h7F,  8'h7F,  16'h3F01};
    vecs[6] = '{8'h80,  8'h01,  16'hFF80};
    vecs[7] = '{8'h01,  8'h80,  16'hFF80};
    vecs[8] = '{8'd5,   8'hFA,  16'hFFE2};
    vecs[9] = '{8'hFE,  8'hC0,  16'h0080};

    @(negedge clk);
    check("reset.state", {30'h0, state}, 32'h0);
    check("reset.product", {16'h0, product}, 32'h0);
    check("reset.endSignal", {31'h0, endSignal}, 32'h0);
    check("reset.busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i), 0);

    do_op(8'd7, 8'd3, 16'h0015, "midpulse", 2);

`ifdef BOOTH4_DIGIT_TRACE_EN
    begin
      logic [2:0] exp_dig[4];
      exp_dig[0] = 3'b101; exp_dig[1] = 3'b001; exp_dig[2] = 3'b000; exp_dig[3] = 3'b000;
      check("trace.idle_valid", {31'h0, digit_valid}, 32'h0);
      @(negedge clk);
      multiplicand = 8'd7; multiplier = 8'd3; beginSignal = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        beginSignal = 1'b0;
        if (k <= 4) begin
          check($sformatf("trace.valid%0d", k), {31'h0, digit_valid}, 32'h1);
          check($sformatf("trace.digit%0d", k), {29'h0, digit}, {29'h0, exp_dig[k-1]});
        end else begin
          check($sformatf("trace.valid%0d", k), {31'h0, digit_valid}, 32'h0);
        end
      end
    end
`endif

    // Reset during the second ITER cycle discards the operation.
    @(negedge clk);
    multiplicand = 8'd7; multiplier = 8'd3; beginSignal = 1'b1;
    @(posedge clk);
    @(negedge clk);
    beginSignal = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid.state", {30'h0, state}, 32'h0);
    check("rst_mid.product", {16'h0, product}, 32'h0);
    check("rst_mid.busy", {31'h0, busy}, 32'h0);
    check("rst_mid.endSignal", {31'h0, endSignal}, 32'h0);
    ends = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (endSignal) ends++;
    end
    check("rst_mid.no_end", ends, 0);
    do_op(8'd5, 8'hFA, 16'hFFE2, "after_rst", 0);

    // beginSignal held high: three operations back to back.
    ends = 0;
    endcyc[0] = 0; endcyc[1] = 0; endcyc[2] = 0;
    prods[0] = '0; prods[1] = '0; prods[2] = '0;
    @(negedge clk);
    multiplicand = 8'd7; multiplier = 8'd3; beginSignal = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (endSignal) begin
        if (ends < 3) begin
          endcyc[ends] = k;
          prods[ends]  = product;
        end
        ends++;
      end
      if (k == 1) begin multiplicand = 8'h80; multiplier = 8'h80; end
      if (k == 7) begin multiplicand = 8'd5;  multiplier = 8'hFA; end
      if (k == 17) beginSignal = 1'b0;
    end
    check("b2b.ends", ends, 3);
    check("b2b.end0", endcyc[0], 5);
    check("b2b.end1", endcyc[1], 11);
    check("b2b.end2", endcyc[2], 17);
    check("b2b.prod0", {16'h0, prods[0]}, 32'h0015);
    check("b2b.prod1", {16'h0, prods[1]}, 32'h4000);
    check("b2b.prod2", {16'h0, prods[2]}, 32'hFFE2);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rp = ra * rb;
      do_op(ra, rb, rp, $sformatf("rand%0d", i), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
